// File: rtl/reg_bus_master_if.sv
// Byte-wise register bus bundle: command, write-byte and read-byte streams plus the register-bank strobes.
// The master modport is the initiator's view; the slave modport is the driving/observing side.
interface reg_bus_master_if #(
  parameter int pLEN_WIDTH  = 16,
  parameter int pADDR_WIDTH = 6
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [pADDR_WIDTH-1:0] cmd_addr;
  logic [pLEN_WIDTH-1:0]  cmd_len;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [7:0]             wr_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [7:0]             rd_data;
  logic                   rd_last;
  logic                   done;
  logic [pADDR_WIDTH-1:0] reg_address;
  logic [15:0]            reg_bytecnt;
  logic                   reg_read;
  logic                   reg_write;
  logic                   reg_addrvalid;
  logic [7:0]             write_data;
  logic [7:0]             read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, read_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
           reg_address, reg_bytecnt, reg_read, reg_write, reg_addrvalid, write_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, read_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
           reg_address, reg_bytecnt, reg_read, reg_write, reg_addrvalid, write_data
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register bus initiator: expands (dir, addr, len) commands into per-byte reg_write / reg_read accesses,
// sourcing write bytes from a stream and returning read bytes through a single-entry output register.
module reg_bus_master #(
  parameter int pLEN_WIDTH  = 16,
  parameter int pADDR_WIDTH = 6
) (
  input logic              cwusb_clk,
  input logic              reset_n,
  reg_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR, RD_ASSERT, RD_CAPTURE, DONE} state_e;

  localparam logic [pLEN_WIDTH-1:0] LenOne = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [pLEN_WIDTH-1:0]  len_q;
  logic [15:0]            byteCnt_q;
  logic [7:0]             rdData_q;
  logic                   rdValid_q;
  logic                   rdLast_q;

  logic [pLEN_WIDTH-1:0]  lenM1;
  logic                   lastByte;
  logic                   regRead;

  assign lenM1    = len_q - LenOne;
  assign lastByte = (byteCnt_q == 16'(lenM1));

  // A read is only launched when the output register is guaranteed free at the capture edge,
  // because the target pops its FIFO on reg_read and the byte cannot be requested again.
  assign regRead  = (state_q == RD_ASSERT) && (!rdValid_q || bus.rd_ready);

  assign bus.cmd_ready     = reset_n && (state_q == IDLE) && !rdValid_q;
  assign bus.wr_ready      = (state_q == WR);
  assign bus.reg_write     = (state_q == WR) && bus.wr_valid;
  assign bus.write_data    = (state_q == WR) ? bus.wr_data : 8'h00;
  assign bus.reg_read      = regRead;
  assign bus.reg_addrvalid = (state_q == WR) || (state_q == RD_ASSERT) || (state_q == RD_CAPTURE);
  assign bus.reg_address   = addr_q;
  assign bus.reg_bytecnt   = byteCnt_q;
  assign bus.done          = (state_q == DONE);
  assign bus.rd_valid      = rdValid_q;
  assign bus.rd_data       = rdData_q;
  assign bus.rd_last       = rdLast_q;

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      byteCnt_q <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      rdLast_q  <= 1'b0;
    end else begin
      if (rdValid_q && bus.rd_ready) begin
        rdValid_q <= 1'b0;
        rdLast_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && !rdValid_q) begin
            addr_q    <= bus.cmd_addr;
            len_q     <= bus.cmd_len;
            byteCnt_q <= '0;
            if (bus.cmd_len == '0)  state_q <= DONE;
            else if (bus.cmd_write) state_q <= WR;
            else                    state_q <= RD_ASSERT;
          end
        end
        WR: begin
          if (bus.wr_valid) begin
            byteCnt_q <= byteCnt_q + 16'd1;
            if (lastByte) state_q <= DONE;
          end
        end
        RD_ASSERT: begin
          if (regRead) state_q <= RD_CAPTURE;
        end
        // Address and byte count stay put here so the target's bytecnt mux still selects this byte.
        RD_CAPTURE: begin
          rdData_q  <= bus.read_data;
          rdValid_q <= 1'b1;
          rdLast_q  <= lastByte;
          byteCnt_q <= byteCnt_q + 16'd1;
          state_q   <= lastByte ? DONE : RD_ASSERT;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed and randomized bench for reg_bus_master; expected bus beats and read bytes come from
// per-command transaction queues built from the command itself and a simple register-target model.
module tb_reg_bus_master;

  localparam int LW = 16;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_bus_master_if #(.pLEN_WIDTH(LW), .pADDR_WIDTH(AW)) bus ();

  reg_bus_master #(.pLEN_WIDTH(LW), .pADDR_WIDTH(AW)) dut (
    .cwusb_clk (clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit rdStall, rdRand, wrRand, simpleRead;
  int wrGap;
  int gapCnt;

  logic [7:0]  wrSrcQ[$];
  logic [7:0]  presetQ[$];
  logic [31:0] expWr[$];
  logic [31:0] wrQ[$];
  logic [31:0] rdReqQ[$];
  logic [31:0] rdOutQ[$];

  int doneCnt, doneCyc, acceptCyc, avCnt;
  int protoViol, stableViol, stallViol, holdViol;
  int firstRdCyc, lastRdCyc, firstWrCyc, lastWrCyc;
  bit wrFire, prevRead, pendRead;
  logic [AW-1:0] prevAddr, pendAddr;
  logic [15:0]   prevCnt, pendCnt;

  function automatic logic [7:0] readModel(input logic [AW-1:0] a, input logic [15:0] b);
    if (simpleRead) return 8'h10 + b[7:0];
    return 8'(b[7:0] * 8'd3) ^ {a, 2'b10};
  endfunction

  always @(posedge clk) cyc++;

  // Register target: data for the byte requested on reg_read appears the following cycle, junk otherwise.
  always @(posedge clk) begin
    #1;
    bus.read_data = pendRead ? readModel(pendAddr, pendCnt) : 8'($urandom);
  end

  always @(posedge clk) begin
    #1;
    bus.rd_ready = rdStall ? 1'b0 : (rdRand ? ($urandom_range(3, 0) != 0) : 1'b1);
  end

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'h00;
      gapCnt       = 0;
    end else begin
      if (wrFire && wrSrcQ.size() > 0) begin
        void'(wrSrcQ.pop_front());
        gapCnt = wrGap;
      end
      if (gapCnt > 0) begin
        bus.wr_valid = 1'b0;
        gapCnt--;
      end else if (wrSrcQ.size() > 0 && (!wrRand || $urandom_range(2, 0) != 0)) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wrSrcQ[0];
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'($urandom);
      end
    end
  end

  // Bus observer: logs beats, stream transfers and protocol violations for the current command.
  always @(negedge clk) begin
    if (!reset_n) begin
      wrFire   = 1'b0;
      prevRead = 1'b0;
      pendRead = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) acceptCyc = cyc;
      if (bus.done) begin
        doneCnt++;
        doneCyc = cyc;
        if (bus.reg_addrvalid) protoViol++;
      end
      if (bus.reg_addrvalid) avCnt++;
      if (bus.reg_read && bus.reg_write) protoViol++;
      if ((bus.reg_read || bus.reg_write) && !bus.reg_addrvalid) protoViol++;
      if (prevRead && (bus.reg_read || bus.reg_address != prevAddr || bus.reg_bytecnt != prevCnt))
        stableViol++;
      if (bus.reg_read) begin
        if (rdReqQ.size() == 0) firstRdCyc = cyc;
        lastRdCyc = cyc;
        rdReqQ.push_back({10'b0, bus.reg_address, bus.reg_bytecnt});
        if (bus.rd_valid && !bus.rd_ready) stallViol++;
      end
      if (bus.reg_write) begin
        if (wrQ.size() == 0) firstWrCyc = cyc;
        lastWrCyc = cyc;
        wrQ.push_back({2'b00, bus.reg_address, bus.reg_bytecnt, bus.write_data});
      end
      if (bus.wr_ready && !bus.wr_valid && bus.reg_bytecnt != 16'(wrQ.size())) holdViol++;
      if (bus.rd_valid && bus.rd_ready) rdOutQ.push_back({23'b0, bus.rd_last, bus.rd_data});
      wrFire   = bus.wr_valid && bus.wr_ready;
      prevRead = bus.reg_read;
      prevAddr = bus.reg_address;
      prevCnt  = bus.reg_bytecnt;
      pendRead = bus.reg_read;
      pendAddr = bus.reg_address;
      pendCnt  = bus.reg_bytecnt;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s observed timeout expected event", tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".strobes"}, {29'b0, bus.reg_read, bus.reg_write, bus.reg_addrvalid}, 32'h0);
    checkOutput({tag, ".rdStream"}, {22'b0, bus.rd_valid, bus.rd_last, bus.rd_data}, 32'h0);
    checkOutput({tag, ".handshake"}, {29'b0, bus.cmd_ready, bus.wr_ready, bus.done}, 32'h0);
    checkOutput({tag, ".bytecnt"}, {16'b0, bus.reg_bytecnt}, 32'h0);
    checkOutput({tag, ".addrData"}, {18'b0, bus.reg_address, bus.write_data}, 32'h0);
  endtask

  task automatic startCmd(input logic w, input logic [AW-1:0] a, input int len);
    logic [7:0] d;
    @(posedge clk);
    #2;
    wrQ.delete(); rdReqQ.delete(); rdOutQ.delete(); expWr.delete();
    doneCnt = 0; doneCyc = 0; acceptCyc = -1; avCnt = 0;
    protoViol = 0; stableViol = 0; stallViol = 0; holdViol = 0;
    firstRdCyc = 0; lastRdCyc = 0; firstWrCyc = 0; lastWrCyc = 0;
    if (w) begin
      for (int i = 0; i < len; i++) begin
        d = (presetQ.size() > 0) ? presetQ.pop_front() : 8'($urandom);
        wrSrcQ.push_back(d);
        expWr.push_back({2'b00, a, 16'(i), d});
      end
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = LW'(len);
    for (int k = 0; k < 500 && acceptCyc < 0; k++) @(posedge clk);
    if (acceptCyc < 0) timeoutFail("cmdAccept");
    #2;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_len   = LW'($urandom);
  endtask

  task automatic finishCmd(input logic w, input logic [AW-1:0] a, input int len,
                           input int expLat, input bit spacing);
    for (int k = 0; k < 5000 && doneCnt == 0; k++) @(posedge clk);
    if (doneCnt == 0) timeoutFail("doneWait");
    if (!w) begin
      for (int k = 0; k < 5000 && rdOutQ.size() < len; k++) @(posedge clk);
      if (rdOutQ.size() < len) timeoutFail("rdDrain");
    end
    repeat (3) @(posedge clk);
    #2;
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("protocol", protoViol, 0);
    checkOutput("readHeld", stableViol, 0);
    checkOutput("readWhileFull", stallViol, 0);
    if (w) begin
      checkOutput("wrCount", wrQ.size(), len);
      for (int i = 0; i < len && i < wrQ.size(); i++)
        checkOutput($sformatf("wrBeat%0d", i), wrQ[i], expWr[i]);
      checkOutput("noReadOnWrite", rdReqQ.size(), 0);
      checkOutput("holdWhenIdle", holdViol, 0);
      if (spacing && len > 0) checkOutput("wrBackToBack", lastWrCyc - firstWrCyc, len - 1);
    end else begin
      checkOutput("rdReqCount", rdReqQ.size(), len);
      for (int i = 0; i < len && i < rdReqQ.size(); i++)
        checkOutput($sformatf("rdReq%0d", i), rdReqQ[i], {10'b0, a, 16'(i)});
      checkOutput("rdOutCount", rdOutQ.size(), len);
      for (int i = 0; i < len && i < rdOutQ.size(); i++)
        checkOutput($sformatf("rdByte%0d", i), rdOutQ[i],
                    {23'b0, (i == len - 1), readModel(a, 16'(i))});
      checkOutput("noWriteOnRead", wrQ.size(), 0);
      if (spacing && len > 0) checkOutput("rdEvery2nd", lastRdCyc - firstRdCyc, 2 * (len - 1));
    end
    if (len == 0) checkOutput("noAddrValid", avCnt, 0);
    if (expLat >= 0) checkOutput("doneLatency", doneCyc - acceptCyc, expLat);
  endtask

  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input int len,
                               input int expLat, input bit spacing);
    startCmd(w, a, len);
    finishCmd(w, a, len, expLat, spacing);
  endtask

  initial begin
    int n1, n2, len;
    logic w;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    rdStall = 0; rdRand = 0; wrRand = 0; wrGap = 0; simpleRead = 1;

    repeat (3) @(posedge clk);
    #2;
    checkAllZero("reset");
    #1 reset_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("cmdReadyIdle", bus.cmd_ready, 1);

    presetQ.push_back(8'hAA); presetQ.push_back(8'hBB); presetQ.push_back(8'hCC);
    applyStimulus(1'b1, 6'h05, 3, 4, 1'b1);
    applyStimulus(1'b0, 6'h02, 4, 9, 1'b1);

    startCmd(1'b0, 6'h11, 3);
    for (int k = 0; k < 100 && !bus.rd_valid; k++) begin
      @(posedge clk);
      #2;
    end
    if (!bus.rd_valid) timeoutFail("firstByte");
    rdStall = 1;
    @(posedge clk);
    #2;
    n1 = rdReqQ.size();
    repeat (4) @(posedge clk);
    #2;
    n2 = rdReqQ.size();
    rdStall = 0;
    checkOutput("noReadWhileStalled", n2 - n1, 0);
    checkOutput("heldOneByte", rdOutQ.size(), 1);
    finishCmd(1'b0, 6'h11, 3, -1, 1'b0);

    wrGap = 3;
    applyStimulus(1'b1, 6'h2A, 2, 6, 1'b0);
    checkOutput("wrGapSpacing", lastWrCyc - firstWrCyc, 4);
    wrGap = 0;

    applyStimulus(1'b1, 6'h07, 0, 1, 1'b0);
    applyStimulus(1'b0, 6'h08, 0, 1, 1'b0);
    applyStimulus(1'b1, 6'h3F, 1, 2, 1'b1);
    applyStimulus(1'b0, 6'h00, 1, 3, 1'b1);

    startCmd(1'b0, 6'h13, 6);
    for (int k = 0; k < 200 && rdOutQ.size() < 2; k++) @(posedge clk);
    if (rdOutQ.size() < 2) timeoutFail("twoBytes");
    #3 reset_n = 1'b0;
    #1;
    checkAllZero("midReset");
    wrSrcQ.delete();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    checkOutput("noDoneAbandoned", doneCnt, 0);
    applyStimulus(1'b0, 6'h13, 3, 7, 1'b1);

    rdRand = 1; wrRand = 1; simpleRead = 0;
    for (int t = 0; t < 16; t++) begin
      w   = 1'($urandom);
      len = (t % 5 == 4) ? $urandom_range(24, 12) : $urandom_range(9, 0);
      applyStimulus(w, AW'($urandom), len, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
